lc3_control_fsm: RTL and testbench

//  Moore control FSM (ISDU) for the LC-3 datapath; sequences fetch/decode/execute.

---
 rtl/lc3_control_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_fsm.sv
// LC-3 ISDU: Moore control FSM sequencing fetch/decode/execute.
// Optional LC3_PAUSE_EN adds the PAUSE opcode (1101) with LED load and Continue handshake.
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    S_HALTED,
    S_F1,
    S_F2,
    S_F3,
    S_DECODE,
    S_ADD_R,
    S_ADD_I,
    S_AND_R,
    S_AND_I,
    S_NOT,
    S_BR_CHK,
    S_BR_TAKE,
    S_JMP,
    S_JSR_A,
    S_JSR_OFF,
    S_JSR_REG,
    S_LDR_A,
    S_LDR_RD,
    S_LDR_WB,
    S_STR_A,
    S_STR_D,
    S_STR_WR,
    S_PAUSE_1,
    S_PAUSE_W,
    S_PAUSE_2
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

  // Counter idles at zero outside memory states, so every entry starts fresh.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_HALTED: if (Run) state_d = S_F1;
      S_F1:     state_d = S_F2;
      S_F2: begin
        if (last) state_d = S_F3;
        else      cnt_d   = cnt_q + 3'd1;
      end
      S_F3:     state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'b0001: state_d = IR_5 ? S_ADD_I : S_ADD_R;
          4'b0101: state_d = IR_5 ? S_AND_I : S_AND_R;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = S_BR_CHK;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR_A;
          4'b0110: state_d = S_LDR_A;
          4'b0111: state_d = S_STR_A;
`ifdef LC3_PAUSE_EN
          4'b1101: state_d = S_PAUSE_1;
`endif
          default: state_d = S_F1;
        endcase
      end
      S_BR_CHK: state_d = BEN ? S_BR_TAKE : S_F1;
      S_JSR_A:  state_d = IR_11 ? S_JSR_OFF : S_JSR_REG;
      S_LDR_A:  state_d = S_LDR_RD;
      S_LDR_RD: begin
        if (last) state_d = S_LDR_WB;
        else      cnt_d   = cnt_q + 3'd1;
      end
      S_STR_A:  state_d = S_STR_D;
      S_STR_D:  state_d = S_STR_WR;
      S_STR_WR: begin
        if (last) state_d = S_F1;
        else      cnt_d   = cnt_q + 3'd1;
      end
      S_ADD_R, S_ADD_I, S_AND_R, S_AND_I, S_NOT,
      S_BR_TAKE, S_JMP, S_JSR_OFF, S_JSR_REG, S_LDR_WB:
        state_d = S_F1;
`ifdef LC3_PAUSE_EN
      S_PAUSE_1: state_d = S_PAUSE_W;
      S_PAUSE_W: if (Continue) state_d = S_PAUSE_2;
      S_PAUSE_2: if (!Continue) state_d = S_F1;
`endif
      default:  state_d = S_HALTED;
    endcase
  end

`ifndef LC3_PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'd0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'd0;
    ALUK       = 2'd0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    case (state_q)
      S_F1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_F2, S_LDR_RD: begin
        Mem_OE = 1'b0;
        LD_MDR = last;
      end
      S_F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD_R, S_ADD_I, S_AND_R, S_AND_I: begin
        SR1MUX  = 1'b1;
        SR2MUX  = (state_q == S_ADD_I) || (state_q == S_AND_I);
        ALUK    = (state_q == S_AND_R || state_q == S_AND_I) ? 2'd1 : 2'd0;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_NOT: begin
        ALUK    = 2'd2;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_BR_TAKE: begin
        ADDR2MUX = 2'd2;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'd3;
        GateALU = 1'b1;
        PCMUX   = 2'd1;
        LD_PC   = 1'b1;
      end
      S_JSR_A: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_JSR_OFF: begin
        ADDR2MUX = 2'd3;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
      end
      S_JSR_REG: begin
        ADDR1MUX = 1'b1;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
      end
      S_LDR_A, S_STR_A: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'd1;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LDR_WB: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_STR_D: begin
        ALUK    = 2'd3;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_STR_WR: Mem_WE = 1'b0;
`ifdef LC3_PAUSE_EN
      S_PAUSE_1: LD_LED = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: per-cycle expected control words from a
// behavioural instruction model, compared by an independent negedge monitor.
module tb_lc3_control_fsm;

  localparam int MEM_WAIT = 2;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_oe, mem_we;
  } ov_t;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

  int tests  = 0;
  int failed = 0;

  ov_t   exp_q[$];
  string tag_q[$];
  ov_t   plan[$];

  always #5 Clk = ~Clk;

  lc3_control_fsm #(.MEM_WAIT(MEM_WAIT)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  function automatic ov_t idle();
    ov_t o;
    o = '0;
    o.mem_oe = 1'b1;
    o.mem_we = 1'b1;
    return o;
  endfunction

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  always @(negedge Clk) begin
    ov_t   got, e;
    string t;
    got = '{LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
            GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
            SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL %s: got %h required %h", t, got, e);
      end
    end
  end

  task automatic expect_cycle(input ov_t o, input string t);
    exp_q.push_back(o);
    tag_q.push_back(t);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add_mem_read();
    ov_t o;
    for (int i = 0; i < MEM_WAIT; i++) begin
      o = idle();
      o.mem_oe = 1'b0;
      o.ld_mdr = (i == MEM_WAIT - 1);
      plan.push_back(o);
    end
  endtask

  // Reference: the control words an instruction produces, one per cycle, from F1.
  task automatic build(input logic [3:0] op, input logic ir5,
                       input logic ir11, input logic ben);
    ov_t o;
    plan.delete();
    o = idle(); o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; plan.push_back(o);
    add_mem_read();
    o = idle(); o.gate_mdr = 1; o.ld_ir = 1; plan.push_back(o);
    o = idle(); o.ld_ben = 1; plan.push_back(o);
    case (op)
      4'd1, 4'd5: begin
        o = idle(); o.sr1mux = 1; o.sr2mux = ir5;
        o.aluk = (op == 4'd5) ? 2'd1 : 2'd0;
        o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; plan.push_back(o);
      end
      4'd9: begin
        o = idle(); o.aluk = 2'd2; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
        plan.push_back(o);
      end
      4'd0: begin
        plan.push_back(idle());
        if (ben) begin
          o = idle(); o.addr2mux = 2'd2; o.pcmux = 2'd2; o.ld_pc = 1;
          plan.push_back(o);
        end
      end
      4'd12: begin
        o = idle(); o.sr1mux = 1; o.aluk = 2'd3; o.gate_alu = 1;
        o.pcmux = 2'd1; o.ld_pc = 1; plan.push_back(o);
      end
      4'd4: begin
        o = idle(); o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1; plan.push_back(o);
        o = idle(); o.pcmux = 2'd2; o.ld_pc = 1;
        if (ir11) o.addr2mux = 2'd3;
        else      o.addr1mux = 1;
        plan.push_back(o);
      end
      4'd6, 4'd7: begin
        o = idle(); o.addr1mux = 1; o.addr2mux = 2'd1; o.gate_marmux = 1;
        o.ld_mar = 1; plan.push_back(o);
        if (op == 4'd6) begin
          add_mem_read();
          o = idle(); o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1;
          plan.push_back(o);
        end else begin
          o = idle(); o.aluk = 2'd3; o.gate_alu = 1; o.ld_mdr = 1;
          plan.push_back(o);
          for (int i = 0; i < MEM_WAIT; i++) begin
            o = idle(); o.mem_we = 1'b0; plan.push_back(o);
          end
        end
      end
`ifdef LC3_PAUSE_EN
      4'd13: begin
        o = idle(); o.ld_led = 1; plan.push_back(o);
      end
`endif
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ir5,
                           input logic ir11, input logic ben);
    int n;
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    build(op, ir5, ir11, ben);
    n = plan.size();
    for (int i = 0; i < n; i++) begin
      expect_cycle(plan[i], $sformatf("op%0d_b%0d_c%0d", op, ben, i));
      Run = 1'($urandom);
`ifdef LC3_PAUSE_EN
      Continue = 1'b0;
`else
      Continue = 1'($urandom);
`endif
      step();
    end
`ifdef LC3_PAUSE_EN
    if (op == 4'd13) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        Continue = 1'b0; expect_cycle(idle(), "pause_hold"); step();
      end
      Continue = 1'b1; expect_cycle(idle(), "pause_cont1"); step();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        expect_cycle(idle(), "pause2_hold"); step();
      end
      Continue = 1'b0; expect_cycle(idle(), "pause2_rel"); step();
    end
`endif
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'd0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    expect_cycle(idle(), "reset");
    step();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_cycle(idle(), "halted_idle");
      step();
    end
    Run = 1'b1;
    expect_cycle(idle(), "halted_run");
    step();

    run_instr(4'd1, 1'b1, 1'b0, 1'b0);
    run_instr(4'd0, 1'b0, 1'b0, 1'b1);
    run_instr(4'd0, 1'b0, 1'b0, 1'b0);
    run_instr(4'd7, 1'b0, 1'b0, 1'b0);
    run_instr(4'd6, 1'b0, 1'b0, 1'b0);
    run_instr(4'd4, 1'b0, 1'b1, 1'b0);
    run_instr(4'd4, 1'b0, 1'b0, 1'b0);
    run_instr(4'd13, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                1'($urandom));

    // Reset landing in the first LDR read-wait cycle.
    Opcode = 4'd6; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    build(4'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      expect_cycle(plan[i], $sformatf("ldr_pre_c%0d", i));
      step();
    end
    Reset = 1'b1;
    expect_cycle(plan[6], "ldr_rd_at_reset");
    step();
    Reset = 1'b0; Run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_cycle(idle(), "after_reset_idle");
      step();
    end
    Run = 1'b1;
    expect_cycle(idle(), "rerun");
    step();
    run_instr(4'd5, 1'b0, 1'b0, 1'b0);
    run_instr(4'd9, 1'b0, 1'b0, 1'b0);
    run_instr(4'd12, 1'b0, 1'b0, 1'b0);

    @(negedge Clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
